// File: rtl/bram_stream_ctrl.sv
// Load/replay sequencer owning a single BRAM port: buffers a nibble stream into
// consecutive addresses, then replays it in order through a valid/ready output.
module bram_stream_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    input  logic              io_start_read,
    output logic              io_busy,
    output logic [ADDR_W:0]   io_count,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic              io_mem_wen,
    output logic [DATA_W-1:0] io_mem_wdata,
    input  logic [DATA_W-1:0] io_mem_rdata,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_bits
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        LOAD,
        READ,
        WAIT,
        OUT
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] out_buf;

    logic              in_fire;
    logic              start_ok;
    logic [ADDR_W:0]   rd_next;

    assign io_in_ready = !reset && (state == LOAD) && (count < DEPTH_C);
    assign in_fire     = io_in_valid && io_in_ready;
    // A write landing in the same cycle as the start request joins the replay.
    assign start_ok    = (state == LOAD) && io_start_read && ((count != '0) || in_fire);
    assign rd_next     = rd_ptr + 1'b1;

    assign io_mem_wen   = in_fire;
    assign io_mem_wdata = io_in_bits;
    assign io_mem_addr  = (state == LOAD) ? count[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];

    assign io_out_valid = (state == OUT);
    assign io_out_bits  = out_buf;
    assign io_busy      = (state != LOAD);
    assign io_count     = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            count   <= '0;
            rd_ptr  <= '0;
            out_buf <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) count <= count + 1'b1;
                    if (start_ok) begin
                        rd_ptr <= '0;
                        state  <= READ;
                    end
                end
                READ: state <= WAIT;
                // BRAM read data is registered: it becomes valid the cycle after READ.
                WAIT: begin
                    out_buf <= io_mem_rdata;
                    state   <= OUT;
                end
                OUT: begin
                    if (io_out_ready) begin
                        rd_ptr <= rd_next;
                        if (rd_next == count) begin
                            count <= '0;
                            state <= LOAD;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Scoreboard bench for bram_stream_ctrl with a behavioural BRAM and a queue-based
// model of the load/replay batches.
module tb_bram_stream_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_in_valid = 1'b0;
    logic              io_in_ready;
    logic [DATA_W-1:0] io_in_bits = '0;
    logic              io_start_read = 1'b0;
    logic              io_busy;
    logic [ADDR_W:0]   io_count;
    logic [ADDR_W-1:0] io_mem_addr;
    logic              io_mem_wen;
    logic [DATA_W-1:0] io_mem_wdata;
    logic [DATA_W-1:0] io_mem_rdata = '0;
    logic              io_out_valid;
    logic              io_out_ready = 1'b0;
    logic [DATA_W-1:0] io_out_bits;

    bram_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_start_read(io_start_read),
        .io_busy      (io_busy),
        .io_count     (io_count),
        .io_mem_addr  (io_mem_addr),
        .io_mem_wen   (io_mem_wen),
        .io_mem_wdata (io_mem_wdata),
        .io_mem_rdata (io_mem_rdata),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle registered read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (io_mem_wen) mem[io_mem_addr] <= io_mem_wdata;
        io_mem_rdata <= mem[io_mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [DATA_W-1:0]        store[$];
    logic [DATA_W-1:0]        exp_q[$];
    logic [ADDR_W+DATA_W-1:0] wr_q[$];
    bit                       busy_m = 1'b0;
    int                       exp_valid_cyc = 0;
    int                       n_checks = 0;
    int                       n_pass = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Monitor: memory writes and output stream against the scoreboard queues
    initial begin
        bit                       prev_valid;
        logic [DATA_W-1:0]        prev_bits;
        logic [ADDR_W+DATA_W-1:0] w;
        bit                       last;
        prev_valid = 1'b0;
        prev_bits  = '0;
        forever begin
            @(negedge clk);
            last = 1'b0;
            if (reset) begin
                prev_valid = 1'b0;
                continue;
            end
            if (io_mem_wen) begin
                if (wr_q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    check("write_addr", io_mem_addr, w[ADDR_W+DATA_W-1:DATA_W]);
                    check("write_data", io_mem_wdata, w[DATA_W-1:0]);
                end
            end
            if (io_out_valid) begin
                if (!prev_valid) check("valid_latency", cyc, exp_valid_cyc);
                else check("stall_hold", io_out_bits, prev_bits);
                if (io_out_ready) begin
                    if (exp_q.size() == 0) check("extra_output", 1, 0);
                    else begin
                        check("out_bits", io_out_bits, exp_q.pop_front());
                        if (exp_q.size() == 0) last = 1'b1;
                        else exp_valid_cyc = cyc + 3;
                    end
                end
            end
            prev_valid = io_out_valid && !io_out_ready;
            prev_bits  = io_out_bits;
            if (last) begin
                @(posedge clk);
                busy_m = 1'b0;
            end
        end
    end

    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit st, input bit r);
        int dc;
        bit room, fire, st_ok;
        dc = cyc;
        io_in_valid   = v;
        io_in_bits    = d;
        io_start_read = st;
        io_out_ready  = r;
        room  = !busy_m && (store.size() < DEPTH);
        fire  = v && room;
        st_ok = st && !busy_m && ((store.size() > 0) || fire);
        if (fire) wr_q.push_back({ADDR_W'(store.size()), d});
        @(negedge clk);
        check("in_ready", io_in_ready, room);
        check("busy", io_busy, busy_m);
        if (!busy_m) check("count", io_count, store.size());
        @(posedge clk);
        #1;
        if (fire) store.push_back(d);
        if (st_ok) begin
            foreach (store[i]) exp_q.push_back(store[i]);
            store.delete();
            busy_m = 1'b1;
            exp_valid_cyc = dc + 3;
        end
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        io_in_valid   = 1'b0;
        io_start_read = 1'b0;
        io_out_ready  = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        wr_q.delete();
        store.delete();
        busy_m = 1'b0;
        repeat (n - 1) begin
            @(negedge clk);
            check("rst_in_ready", io_in_ready, 0);
            check("rst_out_valid", io_out_valid, 0);
            check("rst_busy", io_busy, 0);
            check("rst_wen", io_mem_wen, 0);
            check("rst_count", io_count, 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int k;
        k = 0;
        while ((busy_m || exp_q.size() > 0) && k < budget) begin
            step(1'b0, '0, 1'b0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            k++;
        end
        check("drain_done", int'(busy_m || exp_q.size() > 0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, written;
        bit v;
        logic [DATA_W-1:0] d;

        do_reset(3);
        step(1'b0, '0, 1'b0, 1'b0);

        // Three-entry batch, fixed ready
        step(1'b1, 4'hA, 1'b0, 1'b1);
        step(1'b1, 4'h5, 1'b0, 1'b1);
        step(1'b1, 4'hF, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drain(40, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Fill to capacity; the 17th value must be refused
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        drain(100, 1'b0);

        // Empty start is ignored; write+start in one cycle replays one entry
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 4'h7, 1'b1, 1'b1);
        drain(20, 1'b0);

        // Backpressure on the first entry, with start pulses during the stall
        step(1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (7) step(1'b0, '0, 1'b1, 1'b0);
        drain(20, 1'b0);

        // Reset while presenting output abandons the replay
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        do_reset(2);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        drain(20, 1'b0);

        // Randomized batches with input gaps and random output backpressure
        repeat (8) begin
            n = $urandom_range(1, 20);
            written = 0;
            while (written < n) begin
                v = ($urandom % 4) != 0;
                d = DATA_W'($urandom);
                step(v, d, 1'b0, 1'($urandom_range(0, 1)));
                if (v) written++;
            end
            if ($urandom % 2) step(1'b1, DATA_W'($urandom), 1'b1, 1'b1);
            else step(1'b0, '0, 1'b1, 1'b1);
            drain(400, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
